// File: rtl/lab7_qm_aes.sv
// AES-128 encryption core with an SPI-style serial front end. One round per clk cycle.
// Define AES_SBOX_ROM_EN to use a constant S-box table instead of the computed inverse + affine.
module lab7_qm_aes (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic sdi,
    output logic sdo,
    input  logic load,
    output logic done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] INIT  = 3'd1;
    localparam logic [2:0] ROUND = 3'd2;
    localparam logic [2:0] FINAL = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

`ifdef AES_SBOX_ROM_EN
    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

`ifndef AES_SBOX_ROM_EN
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction
`endif

    function automatic logic [7:0] sbox(input logic [7:0] x);
`ifdef AES_SBOX_ROM_EN
        return SBOX_ROM[2047 - 8*int'(x) -: 8];
`else
        logic [7:0] t;
        // x^254 is the multiplicative inverse, and maps 0 to 0
        t = x;
        for (int k = 0; k < 6; k++) t = gf_mul(gf_mul(t, t), x);
        t = gf_mul(t, t);
        return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]}
                 ^ {t[3:0], t[7:4]} ^ 8'h63;
`endif
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [255:0] shreg;
    logic [7:0]   out_cnt;
    logic [6:0]   bit_idx;
    logic [1:0]   load_sync;
    logic         load_prev;
    logic         load_fall;
    logic [2:0]   state;
    logic [3:0]   rnd;
    logic [127:0] st;
    logic [127:0] rk;

    logic [0:15][7:0] s_in, s_sb, s_sr, s_mc;
    logic [31:0]  rot, w_sub, kt, n0, n1, n2, n3;
    logic [127:0] rk_next;

    // Input shifting only while no ciphertext is being held
    always_ff @(posedge sck or posedge reset) begin
        if (reset)      shreg <= '0;
        else if (!done) shreg <= {shreg[254:0], sdi};
    end

    // Counts output bits; saturates at 128 so sdo reads 0 past ct[0]
    always_ff @(negedge sck or posedge reset) begin
        if (reset)                   out_cnt <= '0;
        else if (!done)              out_cnt <= '0;
        else if (out_cnt != 8'd128)  out_cnt <= out_cnt + 8'd1;
    end

    assign bit_idx = 7'd127 - out_cnt[6:0];
    assign sdo     = done & ~out_cnt[7] & st[bit_idx];

    always_comb begin
        s_in = st;
        for (int i = 0; i < 16; i++) s_sb[i] = sbox(s_in[i]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) s_sr[4*c+r] = s_sb[4*((c+r)%4)+r];
        end
        for (int c = 0; c < 4; c++) begin
            s_mc[4*c]   = xtime(s_sr[4*c]) ^ xtime(s_sr[4*c+1]) ^ s_sr[4*c+1]
                        ^ s_sr[4*c+2] ^ s_sr[4*c+3];
            s_mc[4*c+1] = s_sr[4*c] ^ xtime(s_sr[4*c+1]) ^ xtime(s_sr[4*c+2])
                        ^ s_sr[4*c+2] ^ s_sr[4*c+3];
            s_mc[4*c+2] = s_sr[4*c] ^ s_sr[4*c+1] ^ xtime(s_sr[4*c+2])
                        ^ xtime(s_sr[4*c+3]) ^ s_sr[4*c+3];
            s_mc[4*c+3] = xtime(s_sr[4*c]) ^ s_sr[4*c] ^ s_sr[4*c+1]
                        ^ s_sr[4*c+2] ^ xtime(s_sr[4*c+3]);
        end
    end

    assign rot     = {rk[23:0], rk[31:24]};
    assign w_sub   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign kt      = w_sub ^ {rcon(rnd), 24'h000000};
    assign n0      = rk[127:96] ^ kt;
    assign n1      = rk[95:64] ^ n0;
    assign n2      = rk[63:32] ^ n1;
    assign n3      = rk[31:0] ^ n2;
    assign rk_next = {n0, n1, n2, n3};

    assign load_fall = load_prev & ~load_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_sync <= '0;
            load_prev <= 1'b0;
            state     <= IDLE;
            rnd       <= '0;
            st        <= '0;
            rk        <= '0;
            done      <= 1'b0;
        end else begin
            load_sync <= {load_sync[0], load};
            load_prev <= load_sync[1];
            case (state)
                IDLE: if (load_fall) state <= INIT;
                INIT: begin
                    st    <= shreg[255:128] ^ shreg[127:0];
                    rk    <= shreg[127:0];
                    rnd   <= 4'd1;
                    state <= ROUND;
                end
                ROUND: begin
                    st  <= s_mc ^ rk_next;
                    rk  <= rk_next;
                    rnd <= rnd + 4'd1;
                    if (rnd == 4'd9) state <= FINAL;
                end
                FINAL: begin
                    st    <= s_sr ^ rk_next;
                    rk    <= rk_next;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: if (load_sync[1]) begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab7_qm_aes.sv
// Self-checking bench for lab7_qm_aes: serial load, latency, hold, back-to-back and reset abort.
module tb_lab7_qm_aes;

    logic clk = 1'b0;
    logic reset, sck, sdi, load;
    logic sdo, done;

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    lab7_qm_aes dut (
        .clk   (clk),
        .reset (reset),
        .sck   (sck),
        .sdi   (sdi),
        .sdo   (sdo),
        .load  (load),
        .done  (done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic shift_in(input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] ct);
        logic [255:0] v;
        v = {pt, key};
        load = 1'b1;
        #7;
        for (int i = 255; i >= 0; i--) begin
            sdi = v[i];
            #20 sck = 1'b1;
            #20 sck = 1'b0;
        end
        exp_q.push_back(ct);
        #7 load = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 16) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 128'(done && n <= 15), 128'd1);
    endtask

    task automatic shift_out(input string tag);
        logic [127:0] got, exp;
        logic         b;
        got = '0;
        if (exp_q.size() == 0) begin
            check({tag, " queue"}, 128'(exp_q.size()), 128'd1);
            return;
        end
        exp = exp_q.pop_front();
        check({tag, " msb"}, 128'(sdo), 128'(exp[127]));
        for (int i = 127; i >= 0; i--) begin
            #20 sck = 1'b1;
            got[i] = sdo;
            #20 sck = 1'b0;
        end
        check(tag, got, exp);
        #20 sck = 1'b1;
        b = sdo;
        #20 sck = 1'b0;
        check({tag, " tail"}, 128'(b), 128'd0);
    endtask

    task automatic raise_load(input string tag);
        load = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check(tag, 128'(done), 128'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        sck = 1'b0; sdi = 1'b0; load = 1'b0; reset = 1'b1;
        #23;
        check("rst_done", 128'(done), 128'd0);
        check("rst_sdo", 128'(sdo), 128'd0);
        reset = 1'b0;
        #10;

        shift_in(PT1, KEY1, CT1);
        wait_done("lat1");
        shift_out("ct1");

        raise_load("clr1");
        shift_in(PT2, KEY2, CT2);
        wait_done("lat2");
        ok = 1'b1;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (!done) ok = 1'b0;
        end
        check("hold_done", 128'(ok), 128'd1);
        shift_out("ct2");

        raise_load("clr2");
        shift_in(PT1, KEY1, CT1);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_done", 128'(done), 128'd0);
        check("abort_sdo", 128'(sdo), 128'd0);
        void'(exp_q.pop_front());
        #10 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_idle", 128'(done), 128'd0);

        shift_in(PT1, KEY1, CT1);
        wait_done("lat3");
        shift_out("ct3");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
